// File: rtl/sbox_arbiter_if.sv
// Request/response bundle between the two S-box requesters (round datapath D,
// key schedule K) and the shared substitution-lane arbiter.
interface sbox_arbiter_if;
  logic         d_valid;
  logic         d_ready;
  logic [127:0] d_in;
  logic [127:0] d_out;
  logic         d_done;
  logic         k_valid;
  logic         k_ready;
  logic [31:0]  k_in;
  logic [31:0]  k_out;
  logic         k_done;
  logic         busy;

  modport slave (
    input  d_valid, d_in, k_valid, k_in,
    output d_ready, d_out, d_done, k_ready, k_out, k_done, busy
  );

  modport master (
    output d_valid, d_in, k_valid, k_in,
    input  d_ready, d_out, d_done, k_ready, k_out, k_done, busy
  );
endinterface

// File: rtl/sbox_arbiter.sv
// Round-robin sharing of LANES byte-substitution cells between a 16-byte
// SubBytes job (D) and a 4-byte SubWord job (K); results return with a done pulse.
module sbox_arbiter #(
  parameter int LANES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sbox_arbiter_if.slave bus
);

  localparam logic [3:0] LAST_D = 4'(16 / LANES - 1);
  localparam logic [3:0] LAST_K = 4'(4 / LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN_D, RUN_K} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_cnt;
  logic         r_last_k;
  logic [127:0] r_work;
  logic [127:0] w_work_nxt;
  logic [127:0] r_d_out;
  logic [31:0]  r_k_out;
  logic         r_d_done;
  logic         r_k_done;
  logic         w_grant_d;
  logic         w_grant_k;
  logic         w_last;

  function automatic logic [7:0] sbox_cell(input logic [7:0] b);
    return b ^ 8'hFF;
  endfunction

  always_comb begin
    w_grant_d = 1'b0;
    w_grant_k = 1'b0;
    w_last    = 1'b0;
    w_next    = r_state;
    case (r_state)
      IDLE: begin
        // On a tie the requester that did not win last time gets the job.
        w_grant_d = bus.d_valid & (~bus.k_valid | r_last_k);
        w_grant_k = bus.k_valid & (~bus.d_valid | ~r_last_k);
        if (w_grant_d)      w_next = RUN_D;
        else if (w_grant_k) w_next = RUN_K;
      end
      RUN_D: begin
        w_last = (r_cnt == LAST_D);
        if (w_last) w_next = IDLE;
      end
      RUN_K: begin
        w_last = (r_cnt == LAST_K);
        if (w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Lane j rewrites byte cnt*LANES+j of the working register in place.
  always_comb begin
    int b;
    w_work_nxt = r_work;
    for (int j = 0; j < LANES; j++) begin
      b = (int'(r_cnt) * LANES + j) % 16;
      w_work_nxt[8*b +: 8] = sbox_cell(r_work[8*b +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_last_k <= 1'b1;
      r_d_out  <= '0;
      r_k_out  <= '0;
      r_d_done <= 1'b0;
      r_k_done <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_d_done <= 1'b0;
      r_k_done <= 1'b0;
      if (w_grant_d | w_grant_k) begin
        r_cnt    <= 4'd0;
        r_last_k <= w_grant_k;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == RUN_D && w_last) begin
        r_d_out  <= w_work_nxt;
        r_d_done <= 1'b1;
      end
      if (r_state == RUN_K && w_last) begin
        r_k_out  <= w_work_nxt[31:0];
        r_k_done <= 1'b1;
      end
    end
  end

  // Working register carries data only; control decides when it is meaningful.
  always_ff @(posedge clk) begin
    if (w_grant_d)              r_work <= bus.d_in;
    else if (w_grant_k)         r_work <= {96'd0, bus.k_in};
    else if (r_state != IDLE)   r_work <= w_work_nxt;
  end

  assign bus.d_ready = w_grant_d;
  assign bus.k_ready = w_grant_k;
  assign bus.d_out   = r_d_out;
  assign bus.k_out   = r_k_out;
  assign bus.d_done  = r_d_done;
  assign bus.k_done  = r_k_done;
  assign bus.busy    = (r_state != IDLE);

endmodule
